// File: rtl/dec_output_scheduler_if.sv
// Filter-side strobe/result and byte-stream handshake between the scheduler and its neighbours.
// The master side generates dec_tick and sources bytes; the slave side supplies filt_data and byte_ready.
interface dec_output_scheduler_if #(
    parameter int DATA_W = 24
);
    logic              dec_tick;
    logic [DATA_W-1:0] filt_data;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              byte_ready;
    logic              byte_last;

    modport master (
        output dec_tick,
        output byte_out,
        output byte_valid,
        output byte_last,
        input  filt_data,
        input  byte_ready
    );

    modport slave (
        input  dec_tick,
        input  byte_out,
        input  byte_valid,
        input  byte_last,
        output filt_data,
        output byte_ready
    );
endinterface

// File: rtl/dec_output_scheduler.sv
// Decimation strobe, settle-discarding result capture, 2-deep word buffer and MSB-first byte serializer.
// First byte valid 2 clk after cap_en; a stalled sink holds byte_out/byte_last, fills the buffer, then drops words (sticky ovf).
module dec_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot being written, so a full buffer still takes a coincident push.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module dec_output_scheduler #(
    parameter int DATA_W    = 24,
    parameter int SETTLE    = 3,
    parameter int CAP_DELAY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             ratio_sel,
    input  logic                   ovf_clr,
    output logic                   ovf,
    output logic                   settled,
    dec_output_scheduler_if.master bus
);
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B2   = 2'd1,
        B1   = 2'd2,
        B0   = 2'd3
    } ser_state_t;

    logic [1:0]           ratio_q;
    logic                 ratio_chg;
    logic [6:0]           phase;
    logic [6:0]           phase_max;
    logic                 dec_tick;
    logic [CAP_DELAY-1:0] cap_pipe;
    logic                 cap_en;
    logic [SW-1:0]        settle_cnt;
    logic [SW-1:0]        settle_nxt;
    logic                 push_req;
    logic                 drop;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_W-1:0]    fifo_dat;
    logic [DATA_W-1:0]    shift_q;
    ser_state_t           state;
    logic [7:0]           byte_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 accept;

    always_comb begin
        case (ratio_q)
            2'b00:   phase_max = 7'd15;
            2'b01:   phase_max = 7'd31;
            2'b10:   phase_max = 7'd63;
            default: phase_max = 7'd127;
        endcase
    end

    assign ratio_chg    = (ratio_sel != ratio_q);
    assign dec_tick     = (phase == phase_max);
    assign bus.dec_tick = dec_tick;

    // A ratio switch restarts the phase and flushes any tick still in flight to capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_q  <= ratio_sel;
            phase    <= '0;
            cap_pipe <= '0;
        end else begin
            ratio_q <= ratio_sel;
            if (ratio_chg) begin
                phase    <= '0;
                cap_pipe <= '0;
            end else begin
                phase    <= dec_tick ? '0 : phase + 7'd1;
                cap_pipe <= (cap_pipe << 1) | CAP_DELAY'(dec_tick);
            end
        end
    end

    assign cap_en = cap_pipe[CAP_DELAY-1] && !ratio_chg;

    always_comb begin
        settle_nxt = settle_cnt;
        if (ratio_chg) begin
            settle_nxt = SW'(SETTLE);
        end else if (cap_en && (settle_cnt != '0)) begin
            settle_nxt = settle_cnt - 1'b1;
        end
    end

    assign push_req = cap_en && (settle_cnt == '0);
    assign drop     = push_req && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= SW'(SETTLE);
            settled    <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            settle_cnt <= settle_nxt;
            settled    <= !ratio_chg && (settle_nxt == '0);
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    dec_fifo #(
        .W     (DATA_W),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_req),
        .push_dat (bus.filt_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign accept   = valid_q && bus.byte_ready;
    // Reload straight from B0 when another word waits, so back-to-back words have no gap.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == B0) && accept));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        byte_q  <= fifo_dat[DATA_W-1 -: 8];
                        shift_q <= fifo_dat << 8;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state   <= B2;
                    end
                end
                B2: begin
                    if (accept) begin
                        byte_q  <= shift_q[DATA_W-1 -: 8];
                        shift_q <= shift_q << 8;
                        state   <= B1;
                    end
                end
                B1: begin
                    if (accept) begin
                        byte_q  <= shift_q[DATA_W-1 -: 8];
                        shift_q <= shift_q << 8;
                        last_q  <= 1'b1;
                        state   <= B0;
                    end
                end
                B0: begin
                    if (accept) begin
                        if (fifo_pop) begin
                            byte_q  <= fifo_dat[DATA_W-1 -: 8];
                            shift_q <= fifo_dat << 8;
                            valid_q <= 1'b1;
                            last_q  <= 1'b0;
                            state   <= B2;
                        end else begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = valid_q;
    assign bus.byte_last  = last_q;
endmodule

// File: tb/tb_dec_output_scheduler.sv
// Directed bench for dec_output_scheduler: a queue-level model is checked every cycle, with hand-derived pins.
module tb_dec_output_scheduler;
    localparam int SETTLE = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ratio_sel;
    logic       ovf_clr;
    logic       ovf;
    logic       settled;

    dec_output_scheduler_if #(.DATA_W(24)) bus ();

    dec_output_scheduler #(
        .DATA_W    (24),
        .SETTLE    (SETTLE),
        .CAP_DELAY (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ratio_sel (ratio_sel),
        .ovf_clr   (ovf_clr),
        .ovf       (ovf),
        .settled   (settled),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit vary  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (vary && bus.dec_tick) bus.filt_data = bus.filt_data + 24'h010101;
        end
    endtask

    task automatic wait_tick(input string name, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.dec_tick && n < 300);
        if (!bus.dec_tick) chk(name, 32'd0, 32'd1);
    endtask

    // Behavioural model: words waiting, word being sent, byte index, tick phase.
    logic [23:0] m_q[$];
    logic [23:0] m_cur;
    bit          m_busy;
    int          m_idx;
    int          m_settle;
    int          m_elapsed;
    bit          m_ovf;
    bit          m_settled;
    bit          m_cap;
    logic [1:0]  m_ratio;

    always @(negedge clk) begin
        bit exp_tick;
        bit chg;
        bit pop;
        bit drop;
        int r;
        if (!rst_n) begin
            m_q.delete();
            m_busy    = 1'b0;
            m_idx     = 0;
            m_settle  = SETTLE;
            m_elapsed = 0;
            m_ovf     = 1'b0;
            m_settled = 1'b0;
            m_cap     = 1'b0;
            m_ratio   = ratio_sel;
        end else begin
            r        = 16 << m_ratio;
            exp_tick = (m_elapsed == r - 1);
            chk("model_dec_tick", bus.dec_tick, exp_tick);
            chk("model_byte_valid", bus.byte_valid, m_busy);
            if (m_busy) begin
                chk("model_byte_out", bus.byte_out, m_cur[23 - 8*m_idx -: 8]);
                chk("model_byte_last", bus.byte_last, (m_idx == 2));
            end
            chk("model_ovf", ovf, m_ovf);
            chk("model_settled", settled, m_settled);

            chg  = (ratio_sel != m_ratio);
            pop  = (m_q.size() > 0) && (!m_busy || (m_idx == 2 && bus.byte_ready));
            drop = 1'b0;
            if (m_busy && bus.byte_ready) begin
                if (m_idx == 2) m_busy = 1'b0;
                else m_idx++;
            end
            if (pop) begin
                m_cur  = m_q.pop_front();
                m_busy = 1'b1;
                m_idx  = 0;
            end
            if (!chg && m_cap) begin
                if (m_settle > 0) m_settle--;
                else if (m_q.size() < 2) m_q.push_back(bus.filt_data);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (chg) begin
                m_settle  = SETTLE;
                m_elapsed = 0;
                m_cap     = 1'b0;
                m_settled = 1'b0;
            end else begin
                m_cap     = exp_tick;
                m_elapsed = (m_elapsed + 1) % r;
                m_settled = (m_settle == 0);
            end
            m_ratio = ratio_sel;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [23:0] w2;
        rst_n          = 1'b0;
        ratio_sel      = 2'b00;
        ovf_clr        = 1'b0;
        bus.byte_ready = 1'b1;
        bus.filt_data  = 24'hABCDEF;
        step(2);
        rst_n = 1'b1;

        // 1: ticks at 16-cycle spacing, three discarded captures, first word AB CD EF
        chk("reset_valid", bus.byte_valid, 1'b0);
        chk("reset_settled", settled, 1'b0);
        step(14);  chk("tick_before_first", bus.dec_tick, 1'b0);
        step(1);   chk("tick_first", bus.dec_tick, 1'b1);
        step(1);   chk("tick_after_first", bus.dec_tick, 1'b0);
        step(32);  chk("settled_before_3rd", settled, 1'b0);
        step(1);   chk("settled_after_3rd", settled, 1'b1);
        step(16);  chk("idle_before_pop", bus.byte_valid, 1'b0);
        step(1);   chk("b2_valid", bus.byte_valid, 1'b1);
                   chk("b2_byte", bus.byte_out, 8'hAB);
                   chk("b2_last", bus.byte_last, 1'b0);
        step(1);   chk("b1_byte", bus.byte_out, 8'hCD);
                   chk("b1_last", bus.byte_last, 1'b0);
        step(1);   chk("b0_byte", bus.byte_out, 8'hEF);
                   chk("b0_last", bus.byte_last, 1'b1);
        step(1);   chk("idle_after_word", bus.byte_valid, 1'b0);

        // 2: ten stalled cycles on the middle byte
        step(14);
        chk("bp_start_byte", bus.byte_out, 8'hCD);
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_byte", bus.byte_out, 8'hCD);
            chk("bp_hold_valid", bus.byte_valid, 1'b1);
            step(1);
        end
        bus.byte_ready = 1'b1;
        chk("bp_release_byte", bus.byte_out, 8'hCD);
        step(1);   chk("bp_next_byte", bus.byte_out, 8'hEF);
                   chk("bp_next_last", bus.byte_last, 1'b1);
        step(1);   chk("bp_idle", bus.byte_valid, 1'b0);

        // 3: permanent stall fills buffer, fourth stored word is dropped
        bus.byte_ready = 1'b0;
        vary = 1'b1;
        n = 0;
        while (!ovf && n < 100) begin
            step(1);
            n++;
        end
        chk("ovf_rise_cycle", n, 50);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 1'b0);
        wait_tick("ovf_wait_tick", n);
        step(1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", ovf, 1'b1);

        // 4: switch to R=64 with a backlog, then drain
        ratio_sel = 2'b10;
        step(1);
        chk("chg_settled_drop", settled, 1'b0);
        bus.byte_ready = 1'b1;
        n = 1;
        while (!bus.dec_tick && n < 300) begin
            step(1);
            n++;
        end
        chk("chg_first_tick_gap", n, 64);
        wait_tick("chg_wait_tick", n);
        chk("chg_tick_spacing", n, 64);
        n = 0;
        while (!settled && n < 300) begin
            step(1);
            n++;
        end
        chk("chg_resettled", settled, 1'b1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_clear_before_full", ovf, 1'b0);

        // 5: buffer full, B0 accepted in the same cycle as a capture
        bus.byte_ready = 1'b0;
        wait_tick("full_tick1", n);
        wait_tick("full_tick2", n);
        w2 = bus.filt_data;
        wait_tick("full_tick3", n);
        step(63);
        bus.byte_ready = 1'b1;
        step(2);
        chk("coinc_b0_last", bus.byte_last, 1'b1);
        step(1);
        bus.byte_ready = 1'b0;
        chk("coinc_ovf", ovf, 1'b0);
        chk("coinc_no_bubble", bus.byte_valid, 1'b1);
        chk("coinc_next_b2", bus.byte_out, {24'd0, w2[23:16]});
        chk("coinc_next_last", bus.byte_last, 1'b0);

        // 6: async reset in the middle of B1
        wait_tick("pre_rst_tick", n);
        step(2);
        chk("pre_rst_ovf", ovf, 1'b1);
        bus.byte_ready = 1'b1;
        step(1);
        bus.byte_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.byte_valid, 1'b0);
        chk("arst_byte", bus.byte_out, 8'h00);
        chk("arst_tick", bus.dec_tick, 1'b0);
        chk("arst_ovf", ovf, 1'b0);
        chk("arst_settled", settled, 1'b0);
        step(2);
        rst_n = 1'b1;
        bus.byte_ready = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.dec_tick && n < 300);
        chk("rst_first_tick", n, 63);
        n = 0;
        while (!settled && n < 300) begin
            step(1);
            n++;
        end
        chk("rst_resettled", settled, 1'b1);
        n = 0;
        while (!bus.byte_valid && n < 100) begin
            step(1);
            n++;
        end
        chk("rst_stream_resumes", bus.byte_valid, 1'b1);
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
